// File: rtl/ternary_exec_monitor.sv
// ---------------------------------------------------------------------------
// ternary_exec_monitor
//
// Debug/execution monitor that sits beside the ternary CPU.
//  * Monitor FSM: counts cycles spent running and retired PC changes,
//    declares a halt when the PC sits still in the fetch state for
//    STALL_CYCLES consecutive edges, and flags a timeout after
//    TIMEOUT_CYCLES running edges. HALTED and TIMEOUT are sticky.
//  * Converter FSM: serially turns one balanced-ternary register
//    (2 bits per trit, most-significant trit first) into a signed
//    binary integer, one trit per clock.
//
// Trit codes match the CPU's trit macros: `_1 = 2'b10 (-1),
// `_0 = 2'b00 (0), `_1_ = 2'b01 (+1); 2'b11 is not a legal trit.
// ---------------------------------------------------------------------------
module ternary_exec_monitor #(
   parameter int TRITS          = 9,
   parameter int NUM_REGS       = 8,
   parameter int IDX_W          = 3,
   parameter int STATE_W        = 3,
   parameter int FETCH_STATE    = 0,
   parameter int STALL_CYCLES   = 5,
   parameter int TIMEOUT_CYCLES = 10000,
   parameter int CNT_W          = 32,
   parameter int INT_W          = 16
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         enable,
   input  logic                         clear,
   input  logic [2*TRITS-1:0]           pc,
   input  logic [STATE_W-1:0]           cpu_state,
   input  logic [NUM_REGS*2*TRITS-1:0]  reg_flat,
   input  logic                         conv_req,
   input  logic [IDX_W-1:0]             conv_idx,
   output logic                         conv_busy,
   output logic                         conv_valid,
   output logic signed [INT_W-1:0]      conv_value,
   output logic                         conv_invalid,
   output logic                         halted,
   output logic                         timed_out,
   output logic [CNT_W-1:0]             cycle_count,
   output logic [CNT_W-1:0]             retired_count
);

   localparam int W       = 2 * TRITS;
   localparam int STALL_W = $clog2(STALL_CYCLES + 1);
   localparam int TC_W    = $clog2(TRITS + 1);

   // Monitor FSM encoding
   localparam logic [1:0] M_IDLE    = 2'd0;
   localparam logic [1:0] M_RUN     = 2'd1;
   localparam logic [1:0] M_HALTED  = 2'd2;
   localparam logic [1:0] M_TIMEOUT = 2'd3;

   // Converter FSM encoding
   localparam logic [1:0] C_IDLE = 2'd0;
   localparam logic [1:0] C_RUN  = 2'd1;
   localparam logic [1:0] C_DONE = 2'd2;

   // Trit codes (same values as the CPU's `_1, `_0, `_1_ macros)
   localparam logic [1:0] TRIT_NEG  = 2'b10;
   localparam logic [1:0] TRIT_ZERO = 2'b00;
   localparam logic [1:0] TRIT_POS  = 2'b01;

   localparam logic [CNT_W-1:0]         CNT_MAX     = '1;
   localparam logic [CNT_W-1:0]         TIMEOUT_HIT = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [STALL_W-1:0]       STALL_HIT   = STALL_W'(STALL_CYCLES);
   localparam logic [STATE_W-1:0]       FETCH_CODE  = STATE_W'(FETCH_STATE);
   localparam logic [TC_W-1:0]          LAST_TRIT   = TC_W'(TRITS - 1);
   localparam logic signed [INT_W-1:0]  ACC_THREE   = INT_W'(3);

   // ------------------------------------------------------------------------
   // Monitor FSM
   // ------------------------------------------------------------------------
   logic [1:0]         mon_state;
   logic [W-1:0]       prev_pc;
   logic [STALL_W-1:0] stall_cnt;
   logic [STALL_W-1:0] stall_next;
   logic [CNT_W-1:0]   cycle_inc;
   logic [CNT_W-1:0]   retired_inc;
   logic               pc_same;
   logic               in_fetch;

   assign pc_same  = (pc == prev_pc);
   assign in_fetch = (cpu_state == FETCH_CODE);

   // Saturating increments: the counters stick at all-ones rather than wrap.
   assign cycle_inc   = (cycle_count   == CNT_MAX) ? cycle_count   : cycle_count   + CNT_W'(1);
   assign retired_inc = (retired_count == CNT_MAX) ? retired_count : retired_count + CNT_W'(1);

   // The stall run restarts whenever the PC moves or the CPU leaves fetch.
   // It never passes STALL_CYCLES because reaching it leaves RUN.
   assign stall_next = (pc_same && in_fetch) ? stall_cnt + STALL_W'(1) : '0;

   // Monitor state, counters and sticky flags; clear overrides everything.
   // NOTE: state registers use non-blocking (<=) so every flop samples the
   // pre-edge values, no matter the statement order inside the block.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mon_state     <= M_IDLE;
         prev_pc       <= '0;
         stall_cnt     <= '0;
         cycle_count   <= '0;
         retired_count <= '0;
         halted        <= 1'b0;
         timed_out     <= 1'b0;
      end else if (clear) begin
         mon_state     <= M_IDLE;
         prev_pc       <= '0;
         stall_cnt     <= '0;
         cycle_count   <= '0;
         retired_count <= '0;
         halted        <= 1'b0;
         timed_out     <= 1'b0;
      end else begin
         case (mon_state)
            M_IDLE: begin
               if (enable) begin
                  mon_state     <= M_RUN;
                  prev_pc       <= pc;
                  stall_cnt     <= '0;
                  cycle_count   <= '0;
                  retired_count <= '0;
               end
            end
            M_RUN: begin
               if (!enable) begin
                  // Pausing keeps the counters readable; nothing is counted.
                  mon_state <= M_IDLE;
               end else begin
                  cycle_count <= cycle_inc;
                  stall_cnt   <= stall_next;
                  prev_pc     <= pc;
                  if (!pc_same) begin
                     retired_count <= retired_inc;
                  end
                  // A halt on the same edge as the timeout takes precedence.
                  if (stall_next == STALL_HIT) begin
                     mon_state <= M_HALTED;
                     halted    <= 1'b1;
                  end else if (cycle_inc == TIMEOUT_HIT) begin
                     mon_state <= M_TIMEOUT;
                     timed_out <= 1'b1;
                  end
               end
            end
            default: begin
               // HALTED / TIMEOUT hold until clear or reset.
               mon_state <= mon_state;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Converter FSM
   // ------------------------------------------------------------------------
   logic [1:0]               conv_state;
   logic [W-1:0]             shreg;
   logic signed [INT_W-1:0]  acc;
   logic signed [INT_W-1:0]  acc_next;
   logic [TC_W-1:0]          trit_cnt;
   logic                     bad_idx;
   logic                     bad_code;
   logic [W-1:0]             sel_word;
   logic                     idx_ok;
   logic signed [INT_W-1:0]  trit_val;
   logic                     trit_bad;

   // Register-file mux; an index past the register file selects nothing.
   always_comb begin
      // NOTE: every output of an always_comb gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      sel_word = '0;
      idx_ok   = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (int'(conv_idx) == i) begin
            sel_word = reg_flat[i*W +: W];
            idx_ok   = 1'b1;
         end
      end
   end

   // Decode the trit currently at the top of the shift register.
   always_comb begin
      trit_val = '0;
      trit_bad = 1'b0;
      case (shreg[W-1 -: 2])
         TRIT_POS:  trit_val = INT_W'(1);
         TRIT_NEG:  trit_val = '1;
         TRIT_ZERO: trit_val = '0;
         default:   trit_bad = 1'b1;
      endcase
   end

   // Horner step: consuming MS trit first, acc*3 + t builds the value.
   assign acc_next = acc * ACC_THREE + trit_val;

   assign conv_busy  = (conv_state == C_RUN);
   assign conv_valid = (conv_state == C_DONE);

   // Converter sequencing: accept, TRITS shift edges, one-cycle result.
   // NOTE: the snapshot register and accumulator are plain flops, not a
   // memory, so they are reset with the FSM; a reset mid-conversion must
   // leave no partial result behind.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         conv_state   <= C_IDLE;
         shreg        <= '0;
         acc          <= '0;
         trit_cnt     <= '0;
         bad_idx      <= 1'b0;
         bad_code     <= 1'b0;
         conv_value   <= '0;
         conv_invalid <= 1'b0;
      end else begin
         case (conv_state)
            C_IDLE: begin
               if (conv_req) begin
                  conv_state <= C_RUN;
                  shreg      <= sel_word;
                  acc        <= '0;
                  trit_cnt   <= '0;
                  bad_idx    <= !idx_ok;
                  bad_code   <= !idx_ok;
               end
            end
            C_RUN: begin
               shreg    <= {shreg[W-3:0], 2'b00};
               trit_cnt <= trit_cnt + TC_W'(1);
               // A bad index keeps the timing but never accumulates.
               if (!bad_idx) begin
                  acc      <= acc_next;
                  bad_code <= bad_code | trit_bad;
               end
               if (trit_cnt == LAST_TRIT) begin
                  conv_state   <= C_DONE;
                  conv_value   <= bad_idx ? '0 : acc_next;
                  conv_invalid <= bad_code | (trit_bad & !bad_idx);
               end
            end
            C_DONE: begin
               // Requests seen here are dropped; the next accept is one edge later.
               conv_state <= C_IDLE;
            end
            default: begin
               conv_state <= C_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ternary_exec_monitor.sv
// ---------------------------------------------------------------------------
// tb_ternary_exec_monitor
//
// Self-checking bench: directed scenarios followed by a randomized phase.
// Every output is compared each cycle against a behavioural reference model
// (counters as integers, conversion value as a weighted sum of trits).
// ---------------------------------------------------------------------------
module tb_ternary_exec_monitor;

   localparam int TRITS          = 9;
   localparam int NUM_REGS       = 8;
   localparam int IDX_W          = 4;
   localparam int STATE_W        = 3;
   localparam int FETCH_STATE    = 0;
   localparam int STALL_CYCLES   = 5;
   localparam int TIMEOUT_CYCLES = 40;
   localparam int CNT_W          = 32;
   localparam int INT_W          = 16;
   localparam int W              = 2 * TRITS;

   localparam logic [1:0] TP = 2'b01;   // +1
   localparam logic [1:0] TN = 2'b10;   // -1
   localparam logic [1:0] TZ = 2'b00;   //  0
   localparam logic [1:0] TX = 2'b11;   // illegal code

   localparam longint CNT_SAT = (longint'(1) << CNT_W) - 1;

   logic                        clock = 1'b0;
   logic                        reset;
   logic                        enable;
   logic                        clear;
   logic [W-1:0]                pc;
   logic [STATE_W-1:0]          cpu_state;
   logic [NUM_REGS*W-1:0]       reg_flat;
   logic                        conv_req;
   logic [IDX_W-1:0]            conv_idx;
   logic                        conv_busy;
   logic                        conv_valid;
   logic signed [INT_W-1:0]     conv_value;
   logic                        conv_invalid;
   logic                        halted;
   logic                        timed_out;
   logic [CNT_W-1:0]            cycle_count;
   logic [CNT_W-1:0]            retired_count;

   int n_cmp = 0;
   int n_bad = 0;

   ternary_exec_monitor #(
      .TRITS(TRITS), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W), .STATE_W(STATE_W),
      .FETCH_STATE(FETCH_STATE), .STALL_CYCLES(STALL_CYCLES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W), .INT_W(INT_W)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable), .clear(clear),
      .pc(pc), .cpu_state(cpu_state), .reg_flat(reg_flat),
      .conv_req(conv_req), .conv_idx(conv_idx),
      .conv_busy(conv_busy), .conv_valid(conv_valid), .conv_value(conv_value),
      .conv_invalid(conv_invalid), .halted(halted), .timed_out(timed_out),
      .cycle_count(cycle_count), .retired_count(retired_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic signed [63:0] got,
                        input logic signed [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, want);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum {S_IDLE, S_RUN, S_HALT, S_TMO} mode_e;

   mode_e        m_mode;
   logic [W-1:0] m_prev;
   int           m_stall;
   longint       m_cyc, m_ret;
   int           m_left;      // conversion edges still to go (0 = not busy)
   bit           m_done;      // result cycle
   int           m_val;
   bit           m_inv;
   int           p_val;
   bit           p_inv;

   // Value of a register as sum of trit * 3^position.
   function automatic void ref_convert(input logic [NUM_REGS*W-1:0] flat, input int idx,
                                       output int val, output bit inv);
      logic [W-1:0] word;
      logic [1:0]   code;
      int           weight;
      val = 0;
      inv = 1'b0;
      if (idx >= NUM_REGS) begin
         inv = 1'b1;
         return;
      end
      word = flat[idx*W +: W];
      for (int k = 0; k < TRITS; k++) begin
         code   = word[2*k +: 2];
         weight = 3 ** k;
         if (code == TP)      val += weight;
         else if (code == TN) val -= weight;
         else if (code != TZ) inv = 1'b1;
      end
   endfunction

   function automatic void model_reset();
      m_mode = S_IDLE; m_prev = '0; m_stall = 0; m_cyc = 0; m_ret = 0;
      m_left = 0; m_done = 1'b0; m_val = 0; m_inv = 1'b0;
   endfunction

   // Advance the model by one rising edge using the inputs now applied.
   function automatic void model_edge();
      if (clear) begin
         m_mode = S_IDLE; m_stall = 0; m_cyc = 0; m_ret = 0;
      end else if (m_mode == S_IDLE) begin
         if (enable) begin
            m_mode = S_RUN; m_prev = pc; m_stall = 0; m_cyc = 0; m_ret = 0;
         end
      end else if (m_mode == S_RUN) begin
         if (!enable) begin
            m_mode = S_IDLE;
         end else begin
            if (m_cyc < CNT_SAT) m_cyc++;
            if (pc == m_prev && int'(cpu_state) == FETCH_STATE) m_stall++;
            else m_stall = 0;
            if (pc != m_prev && m_ret < CNT_SAT) m_ret++;
            m_prev = pc;
            if (m_stall == STALL_CYCLES)        m_mode = S_HALT;
            else if (m_cyc == TIMEOUT_CYCLES)   m_mode = S_TMO;
         end
      end

      if (m_done) begin
         m_done = 1'b0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            m_done = 1'b1; m_val = p_val; m_inv = p_inv;
         end
      end else if (conv_req) begin
         ref_convert(reg_flat, int'(conv_idx), p_val, p_inv);
         m_left = TRITS;
      end
   endfunction

   task automatic compare_all();
      check("halted",        halted,        m_mode == S_HALT);
      check("timed_out",     timed_out,     m_mode == S_TMO);
      check("cycle_count",   cycle_count,   m_cyc);
      check("retired_count", retired_count, m_ret);
      check("conv_busy",     conv_busy,     m_left > 0);
      check("conv_valid",    conv_valid,    m_done);
      check("conv_value",    conv_value,    m_val);
      check("conv_invalid",  conv_invalid,  m_inv);
   endtask

   // One clock: model and DUT take the same edge, then outputs are compared.
   task automatic step();
      model_edge();
      @(posedge clock);
      #1;
      compare_all();
   endtask

   // Assert reset between edges; outputs must drop immediately.
   task automatic do_reset();
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      compare_all();
      enable = 1'b0; clear = 1'b0; conv_req = 1'b0;
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   task automatic set_reg(input int idx, input logic [W-1:0] word);
      reg_flat[idx*W +: W] = word;
   endtask

   // Request a conversion, wait (bounded) for the result and check it.
   // The accept edge opens busy cycle 1; valid shows in cycle TRITS+1,
   // i.e. TRITS edges after the accept edge.
   task automatic convert_directed(input int idx, input int want_val,
                                   input bit want_inv, input string tag);
      int lat;
      conv_idx = IDX_W'(idx);
      conv_req = 1'b1;
      step();
      conv_req = 1'b0;
      lat = 0;
      while (!conv_valid && lat < 3 * TRITS) begin
         step();
         lat++;
      end
      check({tag, "_latency"}, lat, TRITS);
      check({tag, "_value"},   conv_value, want_val);
      check({tag, "_invalid"}, conv_invalid, want_inv);
      step();
   endtask

   function automatic logic [W-1:0] rand_word();
      logic [W-1:0] w;
      int           r;
      for (int k = 0; k < TRITS; k++) begin
         r = $urandom_range(0, 19);
         if (r == 0)      w[2*k +: 2] = TX;
         else if (r < 7)  w[2*k +: 2] = TP;
         else if (r < 13) w[2*k +: 2] = TN;
         else             w[2*k +: 2] = TZ;
      end
      return w;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1);
   end

   initial begin
      logic [W-1:0] word;
      int           nvalid;

      reset = 1'b0; enable = 1'b0; clear = 1'b0; pc = '0;
      cpu_state = STATE_W'(FETCH_STATE); reg_flat = '0;
      conv_req = 1'b0; conv_idx = '0;
      model_reset();
      #12;
      compare_all();
      @(negedge clock);
      reset = 1'b1;
      step();
      step();

      // Static PC in fetch: halt exactly STALL_CYCLES edges after RUN entry.
      pc = W'(18'h00123);
      enable = 1'b1;
      step();
      repeat (STALL_CYCLES) step();
      check("static_halted",  halted, 1);
      check("static_cycles",  cycle_count, 5);
      check("static_retired", retired_count, 0);
      enable = 1'b0;
      step();
      check("halt_sticky", halted, 1);
      pulse_clear();
      check("clear_halted", halted, 0);
      check("clear_cycles", cycle_count, 0);

      // PC moves for 20 edges, then freezes.
      enable = 1'b1;
      step();
      for (int i = 0; i < 20; i++) begin
         pc = pc + W'(1);
         step();
      end
      repeat (STALL_CYCLES - 1) step();
      check("moving_not_yet_halted", halted, 0);
      step();
      check("moving_halted",  halted, 1);
      check("moving_retired", retired_count, 20);
      pulse_clear();

      // PC always moving: timeout after TIMEOUT_CYCLES run edges.
      step();
      for (int i = 0; i < TIMEOUT_CYCLES; i++) begin
         pc = pc + W'(1);
         step();
      end
      check("timeout_flag",   timed_out, 1);
      check("timeout_halted", halted, 0);
      check("timeout_cycles", cycle_count, TIMEOUT_CYCLES);
      pulse_clear();

      // Halt and timeout on the same edge: halt wins.
      step();
      for (int i = 0; i < TIMEOUT_CYCLES - STALL_CYCLES; i++) begin
         pc = pc + W'(1);
         step();
      end
      repeat (STALL_CYCLES) step();
      check("tie_halted",  halted, 1);
      check("tie_timeout", timed_out, 0);
      pulse_clear();
      enable = 1'b0;
      step();

      // Conversions.
      set_reg(3, {TRITS{TP}});
      set_reg(5, {TRITS{TN}});
      word = '0; word[W-1 -: 2] = TP; word[1:0] = TN;
      set_reg(1, word);
      word[9:8] = TX;
      set_reg(6, word);
      convert_directed(3, 9841, 1'b0, "all_pos");
      convert_directed(5, -9841, 1'b0, "all_neg");
      convert_directed(1, 6560, 1'b0, "pos_zero_neg");
      convert_directed(9, 0, 1'b1, "bad_index");
      convert_directed(6, 6560, 1'b1, "bad_code");

      // A request while busy is dropped, not queued.
      conv_idx = IDX_W'(3); conv_req = 1'b1;
      step();
      conv_req = 1'b0;
      repeat (3) step();
      conv_idx = IDX_W'(5); conv_req = 1'b1;
      step();
      conv_req = 1'b0;
      nvalid = 0;
      repeat (3 * TRITS) begin
         step();
         if (conv_valid) nvalid++;
      end
      check("busy_req_dropped_valids", nvalid, 1);

      // Held request: not accepted in the result cycle, accepted the edge after.
      conv_idx = IDX_W'(3); conv_req = 1'b1;
      step();
      conv_idx = IDX_W'(5);
      repeat (TRITS) step();
      check("b2b_first_value", conv_value, 9841);
      step();
      check("b2b_done_not_accepted", conv_busy, 0);
      step();
      check("b2b_next_accepted", conv_busy, 1);
      conv_req = 1'b0;
      repeat (TRITS + 1) step();
      check("b2b_second_value", conv_value, -9841);

      // Reset mid-conversion: no result pulse, then normal operation.
      conv_idx = IDX_W'(3); conv_req = 1'b1;
      step();
      conv_req = 1'b0;
      repeat (4) step();
      do_reset();
      check("rst_conv_busy", conv_busy, 0);
      nvalid = 0;
      repeat (TRITS + 3) begin
         step();
         if (conv_valid) nvalid++;
      end
      check("rst_no_valid", nvalid, 0);
      convert_directed(3, 9841, 1'b0, "post_reset");

      // Reset while halted, then a fresh run.
      enable = 1'b1;
      step();
      repeat (STALL_CYCLES) step();
      do_reset();
      check("rst_halted", halted, 0);
      check("rst_cycles", cycle_count, 0);
      enable = 1'b1;
      step();
      repeat (STALL_CYCLES) step();
      check("rerun_halted", halted, 1);
      check("rerun_cycles", cycle_count, 5);
      pulse_clear();

      // Randomized phase.
      for (int r = 0; r < NUM_REGS; r++) set_reg(r, rand_word());
      for (int i = 0; i < 1500; i++) begin
         enable    = ($urandom_range(0, 15) != 0);
         clear     = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 3) == 0) pc = W'($urandom);
         cpu_state = ($urandom_range(0, 2) == 0) ? STATE_W'($urandom) : STATE_W'(FETCH_STATE);
         conv_req  = ($urandom_range(0, 3) == 0);
         conv_idx  = IDX_W'($urandom_range(0, 9));
         if ($urandom_range(0, 7) == 0) set_reg($urandom_range(0, NUM_REGS - 1), rand_word());
         if (i % 400 == 200) do_reset();
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ternary_exec_monitor.md
Name: ternary_exec_monitor

Overview:
- Synthesizable execution monitor for the ternary CPU; sits beside the cpu inside system.
- Tracks cycles and retired PC changes, and detects halt when the PC is stuck in fetch. Flags a timeout.
- Serially converts any selected register (balanced ternary, 2 bits/trit) to a signed binary integer for debug readback.

Parameters:
- TRITS, 9, trits per word; bus width is 2*TRITS.
- NUM_REGS, 8, register-file entries visible on reg_flat.
- IDX_W, 3, width of conv_idx.
- STATE_W, 3, width of cpu_state.
- FETCH_STATE, 0, cpu_state value that counts as fetch.
- STALL_CYCLES, 5, consecutive stuck-PC fetch cycles that declare a halt.
- TIMEOUT_CYCLES, 10000, run cycles before a timeout.
- CNT_W, 32, width of the counters.
- INT_W, 16, signed width of conv_value. Must hold ±(3^TRITS-1)/2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  high while the system is executing.
- clear  in  1  synchronous clear: to IDLE, flags and counters cleared.
- pc  in  2*TRITS  cpu program counter.
- cpu_state  in  STATE_W  cpu control state.
- reg_flat  in  NUM_REGS*2*TRITS  register file; reg i is at bits [i*2*TRITS +: 2*TRITS].
- conv_req  in  1  conversion request.
- conv_idx  in  IDX_W  register to convert.
- conv_busy  out  1  conversion in progress.
- conv_valid  out  1  one-cycle pulse: result ready.
- conv_value  out  INT_W  signed result, held until the next accept.
- conv_invalid  out  1  last result had a bad index or a bad trit code.
- halted  out  1  sticky halt flag.
- timed_out  out  1  sticky timeout flag.
- cycle_count  out  CNT_W  edges spent in RUN, saturating.
- retired_count  out  CNT_W  RUN edges where pc differed from the previous pc, saturating.

Behaviour:
- Reset (reset low): all outputs 0; both FSMs idle; internal prev_pc and stall_cnt cleared.
- Monitor FSM has four states: IDLE, RUN, HALTED, TIMEOUT.
- IDLE -> RUN when enable=1. On that edge: prev_pc<=pc; stall_cnt, cycle_count and retired_count <=0.
- Each RUN edge:
  - cycle_count++.
  - If pc==prev_pc and cpu_state==FETCH_STATE, stall_cnt++. Otherwise stall_cnt<=0.
  - If pc!=prev_pc, retired_count++.
  - prev_pc<=pc.
- RUN -> HALTED when the incremented stall_cnt equals STALL_CYCLES; halted<=1.
- RUN -> TIMEOUT when the incremented cycle_count equals TIMEOUT_CYCLES; timed_out<=1.
- If halt and timeout occur on the same edge, halt wins; timed_out stays 0.
- RUN with enable=0 -> IDLE. Counters are frozen and remain readable; flags stay 0.
- HALTED and TIMEOUT are sticky regardless of enable. Only clear or reset leaves them.
- clear: next state IDLE, all flags and counters <=0. clear has priority over every other transition.
- Counters saturate at all-ones.
- Converter FSM has three states: C_IDLE, C_RUN, C_DONE. It runs independently of the monitor FSM and is not affected by clear.
- Accept: on an edge in C_IDLE with conv_req=1, snapshot reg_flat[conv_idx] into a shift register, acc<=0, go to C_RUN; conv_busy=1 from the next cycle.
- conv_req while busy is ignored and is not queued.
- C_RUN takes TRITS edges, most-significant trit first. Each edge: acc<=acc*3+t, with t in {-1,0,+1} per the codebase trit macros `_1, `_0, `_1_.
- Any other 2-bit trit code contributes 0 and sets the invalid bit.
- After the TRITS-th edge, go to C_DONE. In that cycle conv_valid=1, conv_value=acc, conv_invalid is updated, conv_busy=0.
- C_DONE returns to C_IDLE on the next edge. A request seen on that edge is not accepted; the earliest back-to-back accept is the edge after C_DONE.
- Latency: conv_valid is asserted TRITS+1 cycles after the accept edge.
- If conv_idx>=NUM_REGS at accept, no shifting occurs; the result is still delivered after the same latency with conv_value=0 and conv_invalid=1.
- Reset asserted mid-conversion: everything returns to its reset values immediately and no conv_valid pulse is produced.

Test Plan:
- Static pc, enable=1 with cpu_state=FETCH_STATE -> halted=1 exactly 5 edges after RUN entry; cycle_count=5, retired_count=0.
- pc changes every edge for 20 edges, then freezes -> retired_count=20; halted rises 5 edges after the freeze.
- TIMEOUT_CYCLES=8 with pc always changing -> timed_out=1 after 8 run edges. Also, a halt and a timeout on the same edge -> halted=1, timed_out=0.
- TRITS=9, R3 = all `_1_ -> conv_value=9841, valid 10 cycles after accept. All `_1 -> -9841. Trits + (MS), 0x7, - (LS) -> 6560.
- conv_idx=9 with NUM_REGS=8 -> conv_value=0, conv_invalid=1. A bad 2-bit trit code -> conv_invalid=1. A conv_req asserted while busy is dropped.
- reset pulsed low mid-conversion and while HALTED -> all outputs 0 asynchronously; a new run then behaves normally. clear in HALTED -> returns to IDLE with counts 0.
